// File: rtl/muldiv_unit.sv
// Iterative N-bit multiply/divide unit with a start/busy/done handshake and fixed N+1 cycle latency.
// Define MULDIV_DIV_EN to compile in the divider; without it UDIV/SDIV complete normally and return 0.
module muldiv_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   rd_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   rd_out
);
    localparam int CW = $clog2(N);

    // Handshake: start is taken only in IDLE; busy covers RUN and DONE;
    // done is high for exactly the one DONE cycle, when result/rd_out are valid.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic          last;
    logic [1:0]    op_q;
    logic [4:0]    rd_q;
    logic [N-1:0]  m_q;      // multiplicand, or divisor magnitude
    logic [N-1:0]  hi, lo;   // product high/low, or remainder/quotient
    logic [N-1:0]  hi_nx, lo_nx, res_nx;
    logic [N:0]    sum;
    logic [N-1:0]  mul_hi, mul_lo;

    assign last = (cnt == CW'(N - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
    assign sum    = {1'b0, hi} + {1'b0, (lo[0] ? m_q : {N{1'b0}})};
    assign mul_hi = sum[N:1];
    assign mul_lo = {sum[0], lo[N-1:1]};

`ifdef MULDIV_DIV_EN
    logic         dz_q, neg_q;
    logic [N:0]   shifted, diff;
    logic [N-1:0] a_mag, b_mag;

    // Restoring step; shifted can reach N+1 bits but the kept remainder always fits in N.
    assign shifted = {hi, lo[N-1]};
    assign diff    = shifted - {1'b0, m_q};
    assign a_mag   = (op == 2'b11 && a[N-1]) ? -a : a;
    assign b_mag   = (op == 2'b11 && b[N-1]) ? -b : b;

    always_comb begin
        hi_nx = mul_hi;
        lo_nx = mul_lo;
        if (op_q[1]) begin
            hi_nx = diff[N] ? shifted[N-1:0] : diff[N-1:0];
            lo_nx = {lo[N-2:0], ~diff[N]};
        end
    end
`else
    assign hi_nx = mul_hi;
    assign lo_nx = mul_lo;
`endif

    always_comb begin
        res_nx = '0;
        case (op_q)
            2'b00: res_nx = lo_nx;
            2'b01: res_nx = hi_nx;
`ifdef MULDIV_DIV_EN
            2'b10: res_nx = dz_q ? '0 : lo_nx;
            2'b11: res_nx = dz_q ? '0 : (neg_q ? -lo_nx : lo_nx);
`endif
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            m_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            rd_out <= '0;
`ifdef MULDIV_DIV_EN
            dz_q   <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    rd_q <= rd_in;
                    cnt  <= '0;
                    hi   <= '0;
`ifdef MULDIV_DIV_EN
                    dz_q  <= (b == '0);
                    neg_q <= (op == 2'b11) && (a[N-1] ^ b[N-1]);
                    if (op[1]) begin
                        m_q <= b_mag;
                        lo  <= a_mag;
                    end else begin
                        m_q <= a;
                        lo  <= b;
                    end
`else
                    m_q <= a;
                    lo  <= b;
`endif
                end
                RUN: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= res_nx;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result/rd/done-cycle, monitor pops on done.
module tb_muldiv_unit;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [N-1:0] a = '0, b = '0;
    logic [4:0]   rd_in = '0;
    logic         busy, done;
    logic [N-1:0] result;
    logic [4:0]   rd_out;

    typedef struct packed {
        logic [N-1:0] res;
        logic [4:0]   rd;
        logic [31:0]  cyc;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    muldiv_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        longint sx, sy;
        p  = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        sx = x;
        sy = y;
        case (o)
            2'b00: return p[N-1:0];
            2'b01: return p[2*N-1:N];
`ifdef MULDIV_DIV_EN
            2'b10: return (y == 0) ? '0 : x / y;
            2'b11: begin
                if (y == 0) return '0;
                if (sx == 64'sh8000_0000_0000_0000 && sy == -1) return x;
                return N'(sx / sy);
            end
`endif
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    int last_issue = 0;

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle got=busy want=idle (cycle %0d)", cyc);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input logic [4:0] r);
        wait_idle();
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        last_issue = cyc;
        exp_q.push_back('{res: model(o, x, y), rd: r, cyc: 32'(cyc + 65)});
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        rd_in = 5'($urandom_range(0, 31));
        op = 2'($urandom_range(0, 3));
        chk("busy_rise", N'(busy), N'(1));
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return N'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=done want=none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("rd_out", N'(rd_out), N'(e.rd));
                chk("done_cycle", N'(cyc), N'(e.cyc));
                chk("busy_at_done", N'(busy), N'(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_result", result, '0);
        chk("rst_rd_out", N'(rd_out), N'(0));
        reset = 1'b0;
        @(negedge clk);

        // directed test plan operations
        do_op(2'b00, 7, 6, 3);
        do_op(2'b01, '1, '1, 4);
        do_op(2'b00, '1, '1, 6);
        do_op(2'b10, 100, 7, 7);
        do_op(2'b11, -64'sd100, 7, 8);
        do_op(2'b10, 5, 0, 9);
        do_op(2'b11, 64'h8000_0000_0000_0000, '1, 31);

        // a second start in cycle 10 is dropped; a start held from 60 through 66 is taken in 66
        do_op(2'b00, 7, 6, 3);
        c0 = last_issue;
        while (cyc < c0 + 10) @(negedge clk);
        op = 2'b01; a = '1; b = '1; rd_in = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 60) @(negedge clk);
        op = 2'b00; a = 11; b = 13; rd_in = 5'd14; start = 1'b1;
        exp_q.push_back('{res: N'(143), rd: 5'd14, cyc: 32'(c0 + 131)});
        while (cyc < c0 + 67) @(negedge clk);
        start = 1'b0;

        // reset in cycle 30 of a UDIV aborts it
        do_op(2'b10, 100, 7, 5);
        c0 = last_issue;
        while (cyc < c0 + 30) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_done", N'(done), N'(0));
        chk("abort_result", result, '0);
        chk("abort_rd_out", N'(rd_out), N'(0));
        @(negedge clk);
        reset = 1'b0;
        do_op(2'b00, 3, 3, 2);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [1:0] o;
            o = 2'($urandom_range(0, 3));
            do_op(o, pick(), pick(), 5'($urandom_range(0, 31)));
        end

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("queue_drained", N'(exp_q.size()), '0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
